// File: rtl/lmsm_pkg.sv
// Shared types for the load/store-multiple sequencer.
// State encoding and register-list geometry.
package lmsm_pkg;

  localparam int REG_IDX_W = 3;
  localparam int REG_CNT   = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/lmsm_prio_enc.sv
// Lowest-set-bit priority encoder for the register list.
// Index is 0 and valid is 0 when the mask is empty.
module lmsm_prio_enc
  import lmsm_pkg::*;
(
  input  logic [REG_CNT-1:0]   mask,
  output logic [REG_IDX_W-1:0] idx,
  output logic                 valid
);

  always_comb begin
    idx   = '0;
    valid = |mask;
    // Descending scan so the lowest set bit wins.
    for (int i = REG_CNT - 1; i >= 0; i--) begin
      if (mask[i]) idx = REG_IDX_W'(i);
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// Load/store-multiple sequencer: walks the register list
// low to high, one memory transfer per selected register.
module lmsm_sequencer
  import lmsm_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_store,
  input  logic [REG_CNT-1:0]   reg_list,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [REG_IDX_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0]    rf_rdata,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata
);

  state_e               state_q, state_d;
  logic [REG_CNT-1:0]   mask_q, mask_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 store_q, store_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [REG_IDX_W-1:0] idx;
  logic                 idx_vld;
  logic [REG_CNT-1:0]   mask_clr;

  lmsm_prio_enc u_enc (
    .mask  (mask_q),
    .idx   (idx),
    .valid (idx_vld)
  );

  assign mask_clr  = mask_q & ~(REG_CNT'(1) << idx);
  assign rf_raddr  = idx;
  assign mem_wdata = rf_rdata;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    addr_d   = addr_q;
    store_d  = store_q;
    data_d   = data_q;
    busy     = (state_q != IDLE);
    done     = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mask_d  = reg_list;
          addr_d  = base_addr;
          store_d = is_store;
          state_d = (|reg_list) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        mem_req  = idx_vld;
        mem_we   = store_q;
        mem_addr = addr_q;
        if (mem_ack) begin
          if (store_q) begin
            mask_d  = mask_clr;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = (|mask_clr) ? ISSUE : DONE;
          end else begin
            data_d  = mem_rdata;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        rf_we    = idx_vld;
        rf_waddr = idx;
        rf_wdata = data_q;
        mask_d   = mask_clr;
        addr_d   = addr_q + ADDR_W'(1);
        state_d  = (|mask_clr) ? ISSUE : DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      store_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Bench for lmsm_sequencer: memory and register-file models,
// expectations derived from the register list and wait count.
module tb_lmsm_sequencer;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          is_store = 1'b0;
  logic [7:0]    reg_list = '0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [2:0]    rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          rf_we;
  logic [2:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] rf [8];
  logic [DW-1:0] mem [65536];

  lmsm_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .reg_list  (reg_list),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  always #5 clk = ~clk;

  assign rf_rdata = rf[rf_raddr];

  always @(posedge clk) begin
    if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_mem_req"}, 32'(mem_req), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(rf[0]));
    chk({tag, "_rf_we"}, 32'(rf_we), 0);
    chk({tag, "_rf_waddr"}, 32'(rf_waddr), 0);
    chk({tag, "_rf_wdata"}, 32'(rf_wdata), 0);
    chk({tag, "_rf_raddr"}, 32'(rf_raddr), 0);
  endtask

  task automatic run_op(input bit st, input logic [7:0] lst,
                        input logic [AW-1:0] base, input int w,
                        input bit poke);
    logic [AW-1:0] exp_addr [$];
    logic [2:0]    exp_idx [$];
    logic [DW-1:0] exp_data [$];
    logic [AW-1:0] obs_addr [$];
    logic [DW-1:0] obs_mdata [$];
    logic          obs_we [$];
    logic [2:0]    obs_ridx [$];
    logic [DW-1:0] obs_rdata [$];
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic          p_we;
    bit            have_prev;
    int n, cyc, wc, req_cyc, exp_cyc;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (lst[i]) begin
        exp_idx.push_back(3'(i));
        exp_addr.push_back(base + AW'(n));
        n++;
      end
    end
    for (int k = 0; k < n; k++)
      exp_data.push_back(st ? rf[exp_idx[k]] : mem[exp_addr[k]]);
    exp_cyc = (n == 0) ? 1 : n * ((st ? 1 : 2) + w) + 1;

    @(negedge clk);
    start = 1'b1; is_store = st; reg_list = lst; base_addr = base;
    @(negedge clk);
    start = 1'b0;
    reg_list = 8'($urandom); base_addr = AW'($urandom);
    is_store = 1'($urandom);
    cyc = 1; wc = 0; req_cyc = 0; have_prev = 0;
    p_addr = '0; p_wdata = '0; p_we = 1'b0;
    while (1) begin
      chk("busy", 32'(busy), 1);
      if (done) break;
      if (cyc > 300) begin
        chk("timeout", 0, 1);
        break;
      end
      if (mem_req) begin
        req_cyc++;
        chk("mem_we_dir", 32'(mem_we), 32'(st));
        if (have_prev) begin
          chk("hold_addr", 32'(mem_addr), 32'(p_addr));
          chk("hold_we", 32'(mem_we), 32'(p_we));
          chk("hold_wdata", 32'(mem_wdata), 32'(p_wdata));
        end
        if (wc == w) begin
          mem_ack = 1'b1;
          obs_addr.push_back(mem_addr);
          obs_we.push_back(mem_we);
          if (mem_we) begin
            obs_mdata.push_back(mem_wdata);
            mem[mem_addr] = mem_wdata;
          end else begin
            mem_rdata = mem[mem_addr];
          end
          wc = 0; have_prev = 0;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = DW'($urandom);
          wc++; have_prev = 1;
          p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
        end
      end else begin
        mem_ack = 1'($urandom);
        mem_rdata = DW'($urandom);
        have_prev = 0;
      end
      if (rf_we) begin
        obs_ridx.push_back(rf_waddr);
        obs_rdata.push_back(rf_wdata);
      end
      if (poke && cyc == 1) begin
        start = 1'b1; reg_list = ~lst; base_addr = base ^ 16'h0F0F;
        is_store = ~st;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; mem_ack = 1'b0;
    chk("done_cycle", 32'(cyc), 32'(exp_cyc));
    chk("req_cycles", 32'(req_cyc), 32'(n * (w + 1)));
    chk("mem_xfers", 32'(obs_addr.size()), 32'(n));
    chk("rf_writes", 32'(obs_ridx.size()), st ? 0 : 32'(n));
    for (int k = 0; k < n && k < obs_addr.size(); k++) begin
      chk("xfer_addr", 32'(obs_addr[k]), 32'(exp_addr[k]));
      if (st) begin
        chk("store_data", 32'(obs_mdata[k]), 32'(exp_data[k]));
      end else if (k < obs_ridx.size()) begin
        chk("load_idx", 32'(obs_ridx[k]), 32'(exp_idx[k]));
        chk("load_data", 32'(obs_rdata[k]), 32'(exp_data[k]));
      end
    end
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = DW'(i * 40503) ^ 16'hA5C3;
    for (int i = 0; i < 8; i++) rf[i] = DW'($urandom);
    #2;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("post_rst");

    run_op(1'b1, 8'b0000_0101, 16'h0100, 0, 1'b0);
    run_op(1'b0, 8'b1000_0001, 16'h0020, 2, 1'b0);
    run_op(1'b1, 8'h00, 16'h1234, 0, 1'b0);
    run_op(1'b0, 8'h00, 16'h4321, 1, 1'b0);
    run_op(1'b1, 8'hFF, 16'hFFFE, 0, 1'b0);
    run_op(1'b1, 8'h3C, 16'h0200, 1, 1'b1);
    run_op(1'b0, 8'h5A, 16'h0400, 0, 1'b1);
    for (int r = 0; r < 8; r++)
      run_op(1'($urandom), 8'($urandom), AW'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom));

    @(negedge clk);
    start = 1'b1; is_store = 1'b0; reg_list = 8'hFF;
    base_addr = 16'h0040;
    @(negedge clk);
    start = 1'b0;
    mem_ack = 1'b0;
    for (int c = 0; c < 20 && !mem_req; c++) @(negedge clk);
    chk("abort_req_seen", 32'(mem_req), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("abort");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 8'h12, 16'h0300, 1, 1'b0);
    run_op(1'b1, 8'h81, 16'h0010, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lmsm_sequencer.md
# lmsm_sequencer

Multi-cycle controller for load-multiple / store-multiple instructions. Takes an 8-bit register list and a base address, then walks the set bits from lowest to highest index. For each register it issues one memory transaction at consecutive word addresses: a store reads the register file, a load writes it back. It sits between the instruction-decode FSM and the shared memory/register-file ports, and owns the lowest-set-bit priority encoding of the register list.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 16, memory and register-file data width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin an operation; sampled only while busy=0
- is_store  in  1  1 = store-multiple, 0 = load-multiple; latched with start
- reg_list  in  8  register mask, bit i = register i; latched with start
- base_addr  in  ADDR_W  address for the lowest selected register; latched with start
- busy  out  1  high from the cycle after start is accepted through the done cycle
- done  out  1  one-cycle completion pulse
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, valid with mem_req
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data; equals rf_rdata
- mem_ack  in  1  transaction complete; mem_rdata is valid in the same cycle
- mem_rdata  in  DATA_W  read data
- rf_raddr  out  3  register-file read index (combinational read port)
- rf_rdata  in  DATA_W  register-file read data
- rf_we  out  1  register-file write enable
- rf_waddr  out  3  register-file write index
- rf_wdata  out  DATA_W  register-file write data

## Operation
- States: IDLE, ISSUE, WRITE, DONE.
- IDLE
  - On start: latch reg_list into mask, base_addr into addr, and is_store.
  - If the latched mask == 0, go to DONE; otherwise go to ISSUE.
- Index selection: idx = lowest set bit of mask (combinational). rf_raddr = idx at all times.
- ISSUE
  - Drive mem_req=1, mem_addr=addr, mem_we=is_store, mem_wdata=rf_rdata.
  - Hold all request signals stable until mem_ack.
  - Store, on ack: clear mask[idx] and set addr <= addr+1. If the remaining mask is 0, go to DONE; otherwise stay in ISSUE with the next idx.
  - Load, on ack: capture mem_rdata into a data register and go to WRITE.
- WRITE (load only)
  - Drive rf_we=1, rf_waddr=idx, rf_wdata=captured data.
  - Clear mask[idx] and set addr <= addr+1.
  - If the remaining mask is 0, go to DONE; otherwise go to ISSUE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFF+1 wraps to 0x0000, with no error.
- Addresses are consecutive per transfer, independent of register index gaps. Example: mask 0b1000_0001 at base 0x10 gives r0→0x10 and r7→0x11.
- start while busy=1 is ignored. reg_list, base_addr and is_store may change freely after acceptance.
- mem_ack outside ISSUE is ignored.
- Reset is asynchronous and aborts any operation: state → IDLE, mask and addr cleared. An outstanding memory request is dropped; the memory side tolerates this.

## Timing
- Reset values: busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=rf_rdata (comb), rf_we=0, rf_waddr=0, rf_wdata=0, rf_raddr=0.
- start is sampled at edge E0. ISSUE or DONE is entered at E0, and busy rises in the cycle after E0.
- With zero-wait memory (mem_ack in the first request cycle):
  - Store of k registers: k ISSUE cycles, done in cycle k+1.
  - Load of k registers: 2k cycles (ISSUE/WRITE pairs), done in cycle 2k+1.
  - Mask 0: done in cycle 1 with no memory or register-file activity.
- Each wait cycle of mem_ack adds one cycle and holds mem_addr/mem_we/mem_wdata constant.
- A new start is accepted in the IDLE cycle after done, so minimum back-to-back spacing is done + 1.
- The register-file write in WRITE takes effect at the end of that cycle. No bypass to the next store is required, because one operation is load-only or store-only.

## Structure
- Shared package: state enum (IDLE, ISSUE, WRITE, DONE), REG_IDX_W=3, REG_CNT=8.
- Sub-module lmsm_prio_enc: 8-bit mask → 3-bit lowest-set index plus valid; valid=0 and index=0 when the mask is 0.
- The sequencer instantiates one lmsm_prio_enc on its mask register.

## Test plan
- Store, mask 0b0000_0101, base 0x0100, zero-wait ack: writes r0@0x0100 and r2@0x0101; done in cycle 3; busy in cycles 1-3.
- Load, mask 0b1000_0001, base 0x0020, ack delayed 2 cycles per request: rf writes r0←M[0x20] and r7←M[0x21]; request signals stable during waits; done in cycle 9.
- Mask 0x00, either direction: done in cycle 1; mem_req and rf_we never asserted.
- Store, mask 0xFF, base 0xFFFE: addresses 0xFFFE, 0xFFFF, 0x0000…0x0005 for r0…r7.
- start pulsed with different reg_list while busy: ignored; original operation completes unchanged.
- rst_n asserted mid-load while mem_req=1 waits for ack: all outputs return to reset values immediately; a new start after release runs correctly from IDLE.
